// File: rtl/lcd_pkg.sv
// Shared constants and types for the text-LCD sequencer: HD44780 command
// bytes, the blank character and the handshake state encoding.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_CMD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CMD_LINE0    = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE1    = 8'hC0;
    localparam logic [7:0] LCD_BLANK        = 8'h20;

    localparam logic [1:0] LCD_INIT_LAST = 2'd3;

    typedef enum logic [1:0] {
        ST_POWERON,
        ST_ISSUE,
        ST_HOLDOFF,
        ST_WAIT
    } seq_state_e;

    function automatic logic [7:0] initCmd(input logic [1:0] step);
        logic [7:0] cmd;
        case (step)
            2'd0:    cmd = LCD_CMD_FUNC_SET;
            2'd1:    cmd = LCD_CMD_DISP_ON;
            2'd2:    cmd = LCD_CMD_CLEAR;
            default: cmd = LCD_CMD_ENTRY;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd_char_buf.sv
// Character buffer for the two display lines: register file reset to blanks,
// one synchronous write port for the host, one combinational read port.
module lcd_char_buf
    import lcd_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]        wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= LCD_BLANK;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/lcd_text_sequencer.sv
// Feeds the downstream LCD timing stage: power-on wait, HD44780 init list,
// then an endless refresh of both display lines from the character buffer.
module lcd_text_sequencer
    import lcd_pkg::*;
#(
    parameter int POWERON_CYCLES = 750000,
    parameter int COLS           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       lcd_busy,
    output logic       lcd_strobe,
    output logic       lcd_cmd_sel,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       frame_done
);

    localparam int DEPTH  = 2 * COLS;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int COL_W  = $clog2(COLS);
    localparam int CNT_W  = $clog2(POWERON_CYCLES + 1);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        initStep_q, initStep_d;
    logic              initDone_q, initDone_d;
    logic              line_q, line_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              addrCmd_q, addrCmd_d;
    logic              cmdSel_q, cmdSel_d;
    logic [7:0]        data_q, data_d;
    logic              load;
    logic              frameDone;
    logic              initFinish;
    logic [ADDR_W-1:0] rdAddr;
    logic [7:0]        rdData;

    lcd_char_buf #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (wr_en),
        .wr_addr_i(wr_addr),
        .wr_data_i(wr_data),
        .rd_addr_i(rdAddr),
        .rd_data_o(rdData)
    );

    // Handshake sequencing; the step counters advance when WAIT sees busy low,
    // so the byte for the next ISSUE is selected from the advanced (_d) values.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        initStep_d = initStep_q;
        initDone_d = initDone_q;
        line_d     = line_q;
        col_d      = col_q;
        addrCmd_d  = addrCmd_q;
        load       = 1'b0;
        frameDone  = 1'b0;
        initFinish = 1'b0;

        case (state_q)
            ST_POWERON: begin
                if (count_q != CNT_W'(POWERON_CYCLES)) begin
                    count_d = count_q + CNT_W'(1);
                end else if (!lcd_busy) begin
                    state_d = ST_ISSUE;
                    load    = 1'b1;
                end
            end
            ST_ISSUE:   state_d = ST_HOLDOFF;
            ST_HOLDOFF: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!lcd_busy) begin
                    state_d = ST_ISSUE;
                    load    = 1'b1;
                    if (!initDone_q) begin
                        if (initStep_q == LCD_INIT_LAST) begin
                            initDone_d = 1'b1;
                            initFinish = 1'b1;
                        end else begin
                            initStep_d = initStep_q + 2'd1;
                        end
                    end else if (addrCmd_q) begin
                        addrCmd_d = 1'b0;
                    end else if (col_q == COL_W'(COLS - 1)) begin
                        col_d     = '0;
                        line_d    = ~line_q;
                        addrCmd_d = 1'b1;
                        frameDone = line_q;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            default: state_d = ST_POWERON;
        endcase
    end

    assign rdAddr = line_d ? (ADDR_W'(COLS) + ADDR_W'(col_d)) : ADDR_W'(col_d);

    // Byte capture happens on entry to ISSUE, so a host write during the
    // ISSUE cycle itself only shows up on the next frame.
    always_comb begin
        cmdSel_d = cmdSel_q;
        data_d   = data_q;
        if (load) begin
            if (!initDone_d) begin
                cmdSel_d = 1'b1;
                data_d   = initCmd(initStep_d);
            end else if (addrCmd_d) begin
                cmdSel_d = 1'b1;
                data_d   = line_d ? LCD_CMD_LINE1 : LCD_CMD_LINE0;
            end else begin
                cmdSel_d = 1'b0;
                data_d   = rdData;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_POWERON;
            count_q    <= '0;
            initStep_q <= '0;
            initDone_q <= 1'b0;
            line_q     <= 1'b0;
            col_q      <= '0;
            addrCmd_q  <= 1'b1;
            cmdSel_q   <= 1'b0;
            data_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            initStep_q <= initStep_d;
            initDone_q <= initDone_d;
            line_q     <= line_d;
            col_q      <= col_d;
            addrCmd_q  <= addrCmd_d;
            cmdSel_q   <= cmdSel_d;
            data_q     <= data_d;
        end
    end

    assign lcd_strobe  = (state_q == ST_ISSUE);
    assign lcd_cmd_sel = cmdSel_q;
    assign lcd_data    = data_q;
    assign init_done   = initDone_q | initFinish;
    assign frame_done  = frameDone;

endmodule
